// File: rtl/i2s_rx_capture_pkg.sv
// Shared constants, write-FSM encoding and RAM address packing for the
// live I2S capture path and the audio engine that reads the same RAM.
package i2s_rx_capture_pkg;

    localparam int I2S_LINES    = 8;
    localparam int I2S_FRAMES   = 32;
    localparam int I2S_SAMPLE_W = 16;
    localparam int I2S_CHAN_W   = $clog2(I2S_LINES * 2);
    localparam int I2S_FRAME_W  = $clog2(I2S_FRAMES);
    localparam int I2S_LINE_W   = I2S_CHAN_W - 1;
    localparam int I2S_ADDR_W   = I2S_FRAME_W + I2S_CHAN_W;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } wr_state_e;

    // RAM address is {frame, chan} with chan = line*2 + ws (left even, right odd)
    function automatic logic [I2S_ADDR_W-1:0] pack_addr(
        input logic [I2S_FRAME_W-1:0] frame,
        input logic [I2S_LINE_W-1:0]  line,
        input logic                   slot_ws
    );
        return {frame, line, slot_ws};
    endfunction

endpackage

// File: rtl/i2s_rx_capture_sync_edge.sv
// Brings sck/ws/sd into the ck domain through identical 2-flop chains so the
// three stay aligned, then flags sck rising edges and word-select changes.
module i2s_sync_edge #(
    parameter int LINES = 8
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             sck_i,
    input  logic             ws_i,
    input  logic [LINES-1:0] sd_i,
    output logic             sck_rise_o,
    output logic             ws_o,
    output logic             ws_change_o,
    output logic [LINES-1:0] sd_o
);

    logic             sck_meta_q, sck_sync_q, sck_last_q;
    logic             ws_meta_q, ws_sync_q, ws_prev_q;
    logic [LINES-1:0] sd_meta_q, sd_sync_q;

    // Two-stage synchronisers plus one extra sck stage for edge detection
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            sck_meta_q <= 1'b0;
            sck_sync_q <= 1'b0;
            sck_last_q <= 1'b0;
            ws_meta_q  <= 1'b0;
            ws_sync_q  <= 1'b0;
            sd_meta_q  <= '0;
            sd_sync_q  <= '0;
        end else begin
            sck_meta_q <= sck_i;
            sck_sync_q <= sck_meta_q;
            sck_last_q <= sck_sync_q;
            ws_meta_q  <= ws_i;
            ws_sync_q  <= ws_meta_q;
            sd_meta_q  <= sd_i;
            sd_sync_q  <= sd_meta_q;
        end
    end

    assign sck_rise_o  = sck_sync_q & ~sck_last_q;
    assign ws_o        = ws_sync_q;
    assign sd_o        = sd_sync_q;
    assign ws_change_o = sck_rise_o & (ws_sync_q != ws_prev_q);

    // ws as seen on the previous bit-clock rise
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            ws_prev_q <= 1'b0;
        end else if (sck_rise_o) begin
            ws_prev_q <= ws_sync_q;
        end
    end

endmodule

// File: rtl/i2s_rx_capture.sv
// Multi-line I2S receiver: shifts one sample per line per slot, snapshots the
// completed slot and bursts it into the audio-in RAM, one write per line.
module i2s_rx_capture
    import i2s_rx_capture_pkg::*;
#(
    parameter int SAMPLE_W = I2S_SAMPLE_W
) (
    input  logic                  ck,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  sck,
    input  logic                  ws,
    input  logic [I2S_LINES-1:0]  sd,
    output logic                  we,
    output logic [I2S_ADDR_W-1:0] waddr,
    output logic [SAMPLE_W-1:0]   wdata,
    output logic [I2S_FRAME_W-1:0] frame,
    output logic                  frame_done,
    output logic                  overrun
);

    localparam int CNT_W = $clog2(SAMPLE_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SAMPLE_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SAMPLE_W + 1);
    localparam logic [I2S_LINE_W-1:0] LAST_LINE = I2S_LINE_W'(I2S_LINES - 1);

    logic                 sck_rise, ws_sync, ws_change;
    logic [I2S_LINES-1:0] sd_sync;

    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 slot_ws_q, armed_q;
    logic [SAMPLE_W-1:0]  shreg_q [I2S_LINES];
    logic [SAMPLE_W-1:0]  shreg_d [I2S_LINES];
    logic                 capture_bit, snap;

    wr_state_e            state_q;
    logic [I2S_LINE_W-1:0] line_q, line_inc;
    logic                 wr_ws_q, start_q;
    logic [SAMPLE_W-1:0]  hold_q [I2S_LINES];
    logic                 we_q, frame_done_q, overrun_q;
    logic [I2S_ADDR_W-1:0] waddr_q;
    logic [SAMPLE_W-1:0]  wdata_q;
    logic [I2S_FRAME_W-1:0] frame_q;

    i2s_sync_edge #(.LINES(I2S_LINES)) u_sync (
        .ck          (ck),
        .rst         (rst),
        .sck_i       (sck),
        .ws_i        (ws),
        .sd_i        (sd),
        .sck_rise_o  (sck_rise),
        .ws_o        (ws_sync),
        .ws_change_o (ws_change),
        .sd_o        (sd_sync)
    );

    // Bit position within the slot, saturating one past the sample width
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        if (bit_cnt_q != CNT_SAT) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
        end
    end

    // Only bits 1..SAMPLE_W of a slot are shifted in; the ws-change bit is
    // the previous word's LSB
    assign capture_bit = sck_rise && !ws_change && (bit_cnt_q < CNT_FULL);
    assign snap        = capture_bit && (bit_cnt_d == CNT_FULL) && armed_q && enable;

    for (genvar gi = 0; gi < I2S_LINES; gi++) begin : g_line
        assign shreg_d[gi] = {shreg_q[gi][SAMPLE_W-2:0], sd_sync[gi]};
    end

    // Slot framing, arming and per-line shift registers
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            bit_cnt_q <= '0;
            slot_ws_q <= 1'b0;
            armed_q   <= 1'b0;
            for (int i = 0; i < I2S_LINES; i++) shreg_q[i] <= '0;
        end else begin
            if (!enable) begin
                armed_q <= 1'b0;
            end else if (ws_change && !ws_sync) begin
                armed_q <= 1'b1;
            end
            if (sck_rise) begin
                if (ws_change) begin
                    bit_cnt_q <= '0;
                    slot_ws_q <= ws_sync;
                end else begin
                    bit_cnt_q <= bit_cnt_d;
                end
            end
            if (capture_bit) begin
                for (int i = 0; i < I2S_LINES; i++) shreg_q[i] <= shreg_d[i];
            end
        end
    end

    assign line_inc = line_q + 1'b1;

    // Snapshot handling and the write-burst FSM with registered RAM outputs
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            line_q       <= '0;
            wr_ws_q      <= 1'b0;
            start_q      <= 1'b0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            frame_q      <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            for (int i = 0; i < I2S_LINES; i++) hold_q[i] <= '0;
        end else begin
            frame_done_q <= 1'b0;
            start_q      <= 1'b0;
            // A snapshot during a burst would clobber hold_q, so drop it
            if (snap) begin
                if (state_q == ST_WRITE) begin
                    overrun_q <= 1'b1;
                end else begin
                    start_q <= 1'b1;
                    wr_ws_q <= slot_ws_q;
                    for (int i = 0; i < I2S_LINES; i++) hold_q[i] <= shreg_d[i];
                end
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_q) begin
                        state_q <= ST_WRITE;
                        line_q  <= '0;
                        we_q    <= 1'b1;
                        wdata_q <= hold_q[0];
                        waddr_q <= pack_addr(frame_q, '0, wr_ws_q);
                    end
                end
                ST_WRITE: begin
                    if (line_q == LAST_LINE) begin
                        state_q <= ST_IDLE;
                        we_q    <= 1'b0;
                        wdata_q <= '0;
                        waddr_q <= '0;
                        if (wr_ws_q) begin
                            frame_q      <= (frame_q == I2S_FRAME_W'(I2S_FRAMES - 1)) ?
                                            '0 : frame_q + 1'b1;
                            frame_done_q <= 1'b1;
                        end
                    end else begin
                        line_q  <= line_inc;
                        wdata_q <= hold_q[line_inc];
                        waddr_q <= pack_addr(frame_q, line_inc, wr_ws_q);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign we         = we_q;
    assign waddr      = waddr_q;
    assign wdata      = wdata_q;
    assign frame      = frame_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_i2s_rx_capture.sv
// Scoreboard bench: stimulus pushes expected RAM writes / frame_done events,
// negedge monitors pop and compare whenever the DUTs present them.
module tb_i2s_rx_capture;

    typedef struct {
        bit          kind;   // 0 = RAM write, 1 = frame_done
        logic [8:0]  addr;
        logic [15:0] data;
        logic [4:0]  frm;
    } exp_t;

    logic        ck = 1'b0;
    logic        rst = 1'b0;
    // main instance: 16-bit samples, ck = 8x sck
    logic        en_m = 1'b0, sck_m = 1'b0, ws_m = 1'b0;
    logic [7:0]  sd_m = '0;
    logic        we_m, fd_m, ovr_m;
    logic [8:0]  waddr_m;
    logic [15:0] wdata_m;
    logic [4:0]  frame_m;
    // second instance: 2-bit samples at ck = 2x sck so snapshots outrun bursts
    logic        en_o = 1'b0, sck_o = 1'b0, ws_o = 1'b0;
    logic [7:0]  sd_o = '0;
    logic        we_o, fd_o, ovr_o;
    logic [8:0]  waddr_o;
    logic [1:0]  wdata_o;
    logic [4:0]  frame_o;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          main_wr_cnt = 0;
    int          ovr_wr_cnt = 0;
    int          exp_frame = 0;

    i2s_rx_capture dut (
        .ck(ck), .rst(rst), .enable(en_m), .sck(sck_m), .ws(ws_m), .sd(sd_m),
        .we(we_m), .waddr(waddr_m), .wdata(wdata_m), .frame(frame_m),
        .frame_done(fd_m), .overrun(ovr_m)
    );

    i2s_rx_capture #(.SAMPLE_W(2)) dut_ovr (
        .ck(ck), .rst(rst), .enable(en_o), .sck(sck_o), .ws(ws_o), .sd(sd_o),
        .we(we_o), .waddr(waddr_o), .wdata(wdata_o), .frame(frame_o),
        .frame_done(fd_o), .overrun(ovr_o)
    );

    always #5 ck = ~ck;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Main monitor: every write / frame_done must match the queue head
    always @(negedge ck) begin
        exp_t e;
        if (!rst) begin
            if (we_m) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write actual=addr %0h data %0h required=none", waddr_m, wdata_m);
                end else begin
                    e = q.pop_front();
                    checks++;
                    if (e.kind != 1'b0 || e.addr !== waddr_m || e.data !== wdata_m) begin
                        errors++;
                        $display("FAIL write actual=addr %0h data %0h required=kind %0d addr %0h data %0h",
                                 waddr_m, wdata_m, e.kind, e.addr, e.data);
                    end
                    $display("write addr=%0h data=%0h", waddr_m, wdata_m);
                end
                main_wr_cnt++;
            end
            if (fd_m) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_frame_done actual=frame %0d required=none", frame_m);
                end else begin
                    e = q.pop_front();
                    checks++;
                    if (e.kind != 1'b1 || e.frm !== frame_m) begin
                        errors++;
                        $display("FAIL frame_done actual=frame %0d required=kind %0d frame %0d",
                                 frame_m, e.kind, e.frm);
                    end
                    $display("frame_done frame=%0d", frame_m);
                end
            end
        end
    end

    // Overrun-instance monitor: only left bursts survive, data on line k is k[1:0]
    always @(negedge ck) begin
        logic [2:0] lk;
        if (!rst) begin
            if (we_o) begin
                lk = 3'(ovr_wr_cnt % 8);
                chk("ovr_waddr", 32'(waddr_o), 32'({5'd0, lk, 1'b0}));
                chk("ovr_wdata", 32'(wdata_o), 32'(lk[1:0]));
                $display("ovr write addr=%0h data=%0h", waddr_o, wdata_o);
                ovr_wr_cnt++;
            end
            if (fd_o) chk("ovr_frame_done", 32'(fd_o), 32'd0);
        end
    end

    task automatic main_bit(input logic w, input logic [7:0] d);
        @(negedge ck); sck_m = 1'b0; ws_m = w; sd_m = d;
        repeat (3) @(negedge ck);
        @(negedge ck); sck_m = 1'b1;
        repeat (3) @(negedge ck);
    endtask

    // Slot of nbits bits; line k carries base+k in bits 1..16, MSB first
    task automatic send_slot(input logic w, input int nbits, input logic [15:0] base, input int en_at);
        logic [7:0]  d;
        logic [15:0] v;
        for (int b = 0; b < nbits; b++) begin
            if (b == en_at) en_m = 1'b1;
            for (int k = 0; k < 8; k++) begin
                v = base + 16'(k);
                if (b == 0)       d[k] = 1'b1;
                else if (b <= 16) d[k] = v[16 - b];
                else              d[k] = k[0];
            end
            main_bit(w, d);
        end
    endtask

    task automatic push_slot(input logic w, input logic [15:0] base);
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            e.kind = 1'b0;
            e.addr = {5'(exp_frame), 3'(k), w};
            e.data = base + 16'(k);
            e.frm  = '0;
            q.push_back(e);
        end
        if (w) begin
            exp_frame = (exp_frame + 1) % 32;
            e.kind = 1'b1; e.addr = '0; e.data = '0; e.frm = 5'(exp_frame);
            q.push_back(e);
        end
    endtask

    task automatic do_frame(input bit expect_wr);
        if (expect_wr) push_slot(1'b0, 16'h1000);
        send_slot(1'b0, 32, 16'h1000, -1);
        if (expect_wr) push_slot(1'b1, 16'h2000);
        send_slot(1'b1, 32, 16'h2000, -1);
    endtask

    task automatic ovr_slot(input logic w);
        logic [7:0] d;
        logic [2:0] kk;
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 8; k++) begin
                kk = 3'(k);
                if (b == 0)      d[k] = 1'b1;
                else if (w == 0) d[k] = kk[2 - b];
                else             d[k] = ~kk[2 - b];
            end
            @(negedge ck); sck_o = 1'b0; ws_o = w; sd_o = d;
            @(negedge ck); sck_o = 1'b1;
        end
    endtask

    initial begin
        int target;
        bit hit;
        // Reset state
        #2 rst = 1'b1;
        #1;
        chk("rst_we", 32'(we_m), 0);
        chk("rst_waddr", 32'(waddr_m), 0);
        chk("rst_wdata", 32'(wdata_m), 0);
        chk("rst_frame", 32'(frame_m), 0);
        chk("rst_frame_done", 32'(fd_m), 0);
        chk("rst_overrun", 32'(ovr_m), 0);
        repeat (4) @(negedge ck);
        rst = 1'b0;

        // Idle with enable low: monitor flags any write
        do_frame(0);
        do_frame(0);
        chk("idle_frame", 32'(frame_m), 0);
        chk("idle_overrun", 32'(ovr_m), 0);

        // Single frame; enable raised while ws is still high (end of right slot)
        en_m = 1'b1;
        do_frame(1);
        chk("single_frame", 32'(frame_m), 1);
        chk("single_drained", 32'(q.size()), 0);

        // Wrap: frames 1..31, then back to 0, then one more at frame 0
        for (int f = 0; f < 31; f++) do_frame(1);
        chk("wrap_frame_zero", 32'(frame_m), 0);
        do_frame(1);
        chk("wrap_frame_after", 32'(frame_m), 1);
        chk("wrap_drained", 32'(q.size()), 0);

        // Arming: disabled frame, then enable mid right slot
        en_m = 1'b0;
        do_frame(0);
        chk("disabled_frame_held", 32'(frame_m), 1);
        send_slot(1'b0, 32, 16'h1000, -1);
        send_slot(1'b1, 32, 16'h2000, 8);
        chk("arm_no_writes", 32'(frame_m), 1);
        do_frame(1);
        chk("arm_frame", 32'(frame_m), 2);

        // Short left slot is discarded, right slot still writes and completes the frame
        send_slot(1'b0, 10, 16'h1000, -1);
        push_slot(1'b1, 16'h2000);
        send_slot(1'b1, 32, 16'h2000, -1);
        chk("short_frame", 32'(frame_m), 3);
        do_frame(1);
        chk("short_drained", 32'(q.size()), 0);
        chk("main_overrun_clear", 32'(ovr_m), 0);

        // Overrun on the fast instance
        en_o = 1'b1;
        chk("ovr_before", 32'(ovr_o), 0);
        ovr_slot(1'b1);
        for (int i = 0; i < 6; i++) begin
            ovr_slot(1'b0);
            ovr_slot(1'b1);
        end
        repeat (20) @(negedge ck);
        chk("ovr_set", 32'(ovr_o), 1);
        chk("ovr_write_count", 32'(ovr_wr_cnt), 48);
        chk("ovr_frame", 32'(frame_o), 0);
        ovr_slot(1'b0);
        repeat (20) @(negedge ck);
        chk("ovr_sticky", 32'(ovr_o), 1);

        // Async reset mid-burst on the main instance
        target = main_wr_cnt + 3;
        hit = 1'b0;
        push_slot(1'b0, 16'h1000);
        fork
            send_slot(1'b0, 32, 16'h1000, -1);
            begin
                for (int i = 0; i < 2000 && !hit; i++) begin
                    @(negedge ck); #2;
                    if (main_wr_cnt >= target) hit = 1'b1;
                end
                chk("midburst_reached", 32'(hit), 1);
                rst = 1'b1;
                #1;
                chk("rstmid_we", 32'(we_m), 0);
                chk("rstmid_frame", 32'(frame_m), 0);
                chk("rstmid_overrun_main", 32'(ovr_m), 0);
                chk("rstmid_overrun_ovr", 32'(ovr_o), 0);
                q.delete();
                repeat (3) @(negedge ck);
                rst = 1'b0;
            end
        join
        repeat (20) @(negedge ck);
        chk("post_rst_frame", 32'(frame_m), 0);
        chk("post_rst_drained", 32'(q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_rx_capture.md
Name: i2s_rx_capture

Overview:
- Deserialises multi-line I2S microphone audio and writes 16-bit samples into the audio input DP RAM that feeds the sequencer.
- Each data line carries a stereo pair, so one frame is LINES*2 channels. A frame counter advances after every completed stereo frame.
- A one-cycle frame_done pulse marks each completed frame; it is the trigger for the downstream sequencer run.
- Sits between the external I2S pins and the audio_in write port, replacing the host-write path when the engine runs live.

Parameters:
- LINES, 8, number of I2S data lines (2 channels per line)
- FRAMES, 32, frames held in audio RAM; frame counter wraps at FRAMES
- SAMPLE_W, 16, bits captured per slot, MSB first
- CHAN_W, $clog2(LINES*2), channel index width
- FRAME_W, $clog2(FRAMES), frame index width

Ports:
- ck  in  1  system clock; must run at least 4x sck
- rst  in  1  asynchronous, active-high reset
- enable  in  1  capture enable (control register bit)
- sck  in  1  external I2S bit clock, asynchronous to ck
- ws  in  1  external I2S word select; 0 = left, 1 = right
- sd  in  LINES  I2S serial data, one bit per line
- we  out  1  audio RAM write strobe
- waddr  out  FRAME_W+CHAN_W  RAM address {frame, chan}
- wdata  out  SAMPLE_W  sample to write
- frame  out  FRAME_W  frame currently being filled
- frame_done  out  1  one-ck pulse after the last write of a frame
- overrun  out  1  sticky error flag

Behaviour:
- Reset: we, waddr, wdata, frame, frame_done, overrun, bit counter, shift registers and armed are all 0. The FSM goes to IDLE. Reset during WRITE aborts the burst and no further strobes are issued.
- Input sync:
  - sck, ws and sd each pass through the same 2-flop synchroniser, so they stay mutually aligned.
  - sck_rise is a one-cycle pulse on a synchronised 0->1 transition.
  - All capture actions below happen only on cycles where sck_rise is high.
- Slot framing:
  - ws_prev holds ws from the previous sck_rise.
  - On the rise where ws != ws_prev: bit_cnt <= 0 and slot_ws <= ws. The sd bit on that rise belongs to the previous word and is ignored.
  - On each later rise, bit_cnt increments and saturates at SAMPLE_W+1.
  - For bit_cnt 1..SAMPLE_W (after increment), every line shifts its sd bit into shreg[line], MSB first.
  - Bits beyond SAMPLE_W are ignored.
  - If the slot ends (ws toggles) before SAMPLE_W bits are captured, it is discarded with no write.
- Arming:
  - armed is cleared while enable = 0.
  - armed is set on the first ws 1->0 transition seen while enable = 1, so capture always starts on a left slot.
  - The enable 0->1 transition does not by itself start capture.
- Snapshot: the rise that captures bit SAMPLE_W with armed = 1 copies all shregs to hold[] and latches slot_ws. The FSM then goes IDLE->WRITE on the next ck.
- WRITE state (LINES cycles, line = 0..LINES-1):
  - we = 1
  - wdata = hold[line]
  - waddr = {frame, line, slot_ws}, i.e. chan = line*2 + slot_ws
  - After line LINES-1 the FSM returns to IDLE.
  - If slot_ws = 1, then on the same cycle as that return: frame <= (frame+1) mod FRAMES and frame_done = 1 for exactly one cycle.
  - Wrap is from FRAMES-1 to 0.
- Outputs: we/waddr/wdata are registered and hold 0 outside WRITE.
- Overrun: a snapshot arriving while in WRITE sets overrun (sticky until rst) and that snapshot is dropped. The burst in progress completes normally.
- enable falling mid-WRITE: the current burst completes; no new snapshot is taken afterwards.
- frame holds its value across enable toggles and is cleared only by rst.

Decomposition:
- Shared package: SAMPLE_W, LINES, FRAMES, CHAN_W, FRAME_W, the address packing order {frame, chan}, and the write-FSM state encoding (IDLE, WRITE). The same package is used by audio_engine.
- One sub-module: i2s_sync_edge, covering the 2-flop synchronisers, the sck_rise detect and the ws-change detect. Everything else stays flat.

Test Plan:
- Reset/idle: rst pulse, enable = 0, clocks running -> we, frame_done, overrun and frame stay 0 throughout.
- Single frame: enable = 1; ck = 8x sck; send 32-bit slots, left line k = 16'h1000+k, right = 16'h2000+k.
  - After the left slot: 8 writes at addr 2k with data 16'h1000+k.
  - After the right slot: 8 writes at addr 2k+1 with data 16'h2000+k.
  - Then one frame_done pulse and frame = 1.
- Wrap: run 33 frames -> writes for frame 31 use waddr[8:4] = 31; frame then reads 0; frame 32 data lands at addr 0..15.
- Arming: raise enable while ws = 1 mid right slot -> no writes until the next left slot; the first write goes to addr 0 of the current frame.
- Short slot: shorten one left slot to 10 bits -> no writes for that slot; the right slot still writes odd addresses; frame_done still pulses.
- Overrun and async reset:
  - Set ck = 2x sck so a snapshot lands during WRITE -> overrun = 1 and stays 1.
  - Assert rst mid-burst -> we = 0 immediately, frame = 0, overrun = 0.
